divider_32bit: RTL and testbench

DIVIDER_32BIT -- requirements
Module: divider_32bit

---
 rtl/divider_32bit.sv | 145 ++++++++++++++
 tb/tb_divider_32bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first, with a zero-divisor shortcut.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fixup).
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] work;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             zero_div;
    logic             neg_q;
    logic             neg_r;

`ifdef DIV_SIGNED_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction
`else
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return v;
    endfunction
`endif

    // {rem,next bit} is WIDTH+1 bits unsigned, so one extra sign bit keeps the trial difference exact
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] work_next;

    // One restoring shift-subtract step
    always_comb begin
        diff = {1'b0, rem, work[WIDTH-1]} - {2'b00, dsr};
        if (diff[WIDTH+1]) begin
            rem_next  = {rem[WIDTH-2:0], work[WIDTH-1]};
            work_next = {work[WIDTH-2:0], 1'b0};
        end else begin
            rem_next  = diff[WIDTH-1:0];
            work_next = {work[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            work        <= '0;
            dsr         <= '0;
            rem         <= '0;
            zero_div    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work        <= magnitude(dividend);
                        dsr         <= magnitude(divisor);
                        rem         <= '0;
                        cnt         <= '0;
                        zero_div    <= (divisor == '0);
                        busy        <= (divisor != '0);
                        div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`else
                        neg_q       <= 1'b0;
                        neg_r       <= 1'b0;
`endif
                        state       <= CALC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    if (zero_div) begin
                        // Re-signing the magnitude restores the original dividend bit pattern
                        quotient    <= '1;
                        remainder   <= apply_sign(work, neg_r);
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        work <= work_next;
                        rem  <= rem_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            quotient  <= apply_sign(work_next, neg_q);
                            remainder <= apply_sign(rem_next, neg_r);
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: expected results queued at start, checked when done pulses.
module tb_divider_32bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    divider_32bit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dbz = 1'b0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
`ifdef DIV_SIGNED_EN
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
`else
        end else begin
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (done) begin
            check_val("busy_with_done", {63'd0, busy}, 64'd0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("quotient", {32'd0, quotient}, {32'd0, mon_e.q});
                check_val("remainder", {32'd0, remainder}, {32'd0, mon_e.r});
                check_val("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
            end
        end
    end

    // Present operands for one accepting edge; returns 1 time unit after edge k
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke);
        exp_t e;
        int   exp_lat;
        int   cyc;
        int   busy_cyc;
        bit   seen;
        e = model(a, b);
        exp_lat = (b == 32'd0) ? 1 : 32;
        sb_q.push_back(e);
        start_op(a, b);
        cyc = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (busy) busy_cyc++;
            if (poke > 0 && cyc == poke - 1) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val("done_seen", {63'd0, seen}, 64'd1);
        check_val("latency", 64'(cyc), 64'(exp_lat));
        check_val("busy_cycles", 64'(busy_cyc), 64'(exp_lat == 1 ? 0 : exp_lat));
        @(posedge clk); #1;
        check_val("done_single", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        check_val("hold_q", {32'd0, quotient}, {32'd0, e.q});
        check_val("hold_r", {32'd0, remainder}, {32'd0, e.r});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_q", {32'd0, quotient}, 64'd0);
        check_val("rst_r", {32'd0, remainder}, 64'd0);
        check_val("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        run_op(32'd100, 32'd7, 0);
        run_op(32'h0000_1234, 32'd0, 0);
        run_op(32'hFFFF_FFE0, 32'hFFFF_FFF5, 0);
        run_op(32'd5, 32'd10, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        run_op(32'hDEAD_BEEF, 32'h0000_1234, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(32'd100, 32'd7, 10);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom_range(1, 65535), 0);
        end

        // Abort mid-operation: no result expected from this one
        start_op(32'd77, 32'd5);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        check_val("abort_q", {32'd0, quotient}, 64'd0);
        check_val("abort_r", {32'd0, remainder}, 64'd0);
        check_val("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        run_op(32'd9, 32'd3, 0);

        repeat (5) @(posedge clk);
        #2;
        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
